pwm_multiphase: RTL and testbench

- Synthesizable N-channel PWM gate-drive generator: one shared period counter, per-channel duty and phase offset.
- Drives multiphase/interleaved switched-converter models (e.g. the filter sw inputs) on the emulator fabric, replacing the single-phase fixed-duty PWM macro.
- Each channel produces a complementary high-side/low-side pair, with optional dead-time.
- Duty, phase and period are runtime-programmable through shadow registers that commit only at period wrap, so no runt pulses occur.

---
 rtl/pwm_multiphase.sv | 167 ++++++++++++++++
 tb/tb_pwm_multiphase.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multiphase.sv
// rtl/pwm_multiphase.sv - N-channel phase-shifted PWM with complementary gates and wrap-committed shadows
// Optional dead-time insertion: define PWM_MULTIPHASE_DEADTIME_EN.
module pwm_multiphase #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [CNT_W-1:0]        period,
    input  logic [N_CH*CNT_W-1:0]   duty,
    input  logic [N_CH*CNT_W-1:0]   phase,
    input  logic [DT_W-1:0]         dead_time,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    sync,
    output logic [N_CH-1:0]         gate_hi,
    output logic [N_CH-1:0]         gate_lo
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_p;
    logic [CNT_W-1:0] duty_r  [N_CH];
    logic [CNT_W-1:0] phase_r [N_CH];
    logic [CNT_W-1:0] duty_p  [N_CH];
    logic [CNT_W-1:0] phase_p [N_CH];
    logic             pend;
    logic             active;
    logic             wrap;
    logic             commit;
    logic [N_CH-1:0]  raw;
    logic [CNT_W:0]   pos_sum [N_CH];

`ifdef PWM_MULTIPHASE_DEADTIME_EN
    logic [DT_W-1:0]  dt_r;
    logic [DT_W-1:0]  dt_p;
`else
    logic             unused_dead_time;
    assign unused_dead_time = ^dead_time;
`endif

    // Out-of-range phase is clamped to the last slot rather than reduced modulo period.
    function automatic logic [CNT_W-1:0] sat_phase(input logic [CNT_W-1:0] ph,
                                                   input logic [CNT_W-1:0] per);
        if (ph >= per)
            return (per == '0) ? '0 : per - 1'b1;
        return ph;
    endfunction

    assign active = en && (period_r != '0);
    assign wrap   = (period_r == '0) || (cnt == period_r - 1'b1);
    assign commit = pend && (!en || wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sync     <= 1'b0;
            load_ack <= 1'b0;
            pend     <= 1'b0;
            period_r <= '0;
            period_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_r[i]  <= '0;
                phase_r[i] <= '0;
                duty_p[i]  <= '0;
                phase_p[i] <= '0;
            end
`ifdef PWM_MULTIPHASE_DEADTIME_EN
            dt_r <= '0;
            dt_p <= '0;
`endif
        end else begin
            if (active)
                cnt <= wrap ? '0 : cnt + 1'b1;
            else
                cnt <= '0;
            sync     <= active && wrap;
            load_ack <= commit;

            // Commit drains the old pending copy; a coincident load refills it.
            if (commit) begin
                period_r <= period_p;
                for (int i = 0; i < N_CH; i++) begin
                    duty_r[i]  <= duty_p[i];
                    phase_r[i] <= sat_phase(phase_p[i], period_p);
                end
`ifdef PWM_MULTIPHASE_DEADTIME_EN
                dt_r <= dt_p;
`endif
            end

            if (load) begin
                pend     <= 1'b1;
                period_p <= period;
                for (int i = 0; i < N_CH; i++) begin
                    duty_p[i]  <= duty[i*CNT_W +: CNT_W];
                    phase_p[i] <= phase[i*CNT_W +: CNT_W];
                end
`ifdef PWM_MULTIPHASE_DEADTIME_EN
                dt_p <= dead_time;
`endif
            end else if (commit) begin
                pend <= 1'b0;
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos_sum[i] = {1'b0, cnt} + {1'b0, phase_r[i]};
            if (pos_sum[i] >= {1'b0, period_r})
                pos_sum[i] = pos_sum[i] - {1'b0, period_r};
            raw[i] = active && (pos_sum[i] < {1'b0, duty_r[i]});
        end
    end

`ifdef PWM_MULTIPHASE_DEADTIME_EN
    logic [N_CH-1:0] raw_q;
    logic [DT_W-1:0] dt_cnt [N_CH];

    // Any raw edge forces both sides low and (re)starts the per-channel dead-time count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_hi <= '0;
            gate_lo <= '0;
            raw_q   <= '0;
            for (int i = 0; i < N_CH; i++)
                dt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!active) begin
                    gate_hi[i] <= 1'b0;
                    gate_lo[i] <= 1'b0;
                    raw_q[i]   <= 1'b0;
                    dt_cnt[i]  <= '0;
                end else if (raw[i] != raw_q[i]) begin
                    raw_q[i]   <= raw[i];
                    dt_cnt[i]  <= dt_r;
                    gate_hi[i] <= (dt_r == '0) && raw[i];
                    gate_lo[i] <= (dt_r == '0) && !raw[i];
                end else if (dt_cnt[i] != '0) begin
                    dt_cnt[i]  <= dt_cnt[i] - 1'b1;
                    gate_hi[i] <= (dt_cnt[i] == 1) && raw[i];
                    gate_lo[i] <= (dt_cnt[i] == 1) && !raw[i];
                end else begin
                    gate_hi[i] <= raw[i];
                    gate_lo[i] <= !raw[i];
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_hi <= '0;
            gate_lo <= '0;
        end else begin
            gate_hi <= raw;
            gate_lo <= {N_CH{active}} & ~raw;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_multiphase.sv
// tb/tb_pwm_multiphase.sv - randomized and directed bench for pwm_multiphase against a cycle reference model
module tb_pwm_multiphase;
    localparam int N_CH  = 4;
    localparam int CNT_W = 16;
    localparam int DT_W  = 8;
    localparam int BIG   = 1000000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [CNT_W-1:0]      period;
    logic [N_CH*CNT_W-1:0] duty;
    logic [N_CH*CNT_W-1:0] phase;
    logic [DT_W-1:0]       dead_time;
    logic                  load;
    logic                  load_ack;
    logic                  sync;
    logic [N_CH-1:0]       gate_hi;
    logic [N_CH-1:0]       gate_lo;

    pwm_multiphase #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty), .phase(phase),
        .dead_time(dead_time), .load(load), .load_ack(load_ack), .sync(sync),
        .gate_hi(gate_hi), .gate_lo(gate_lo)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: active values, pending copy, counter position, per-channel edge history.
    int m_cnt, m_per, m_dt, m_pend, p_per, p_dt;
    int m_duty [N_CH];
    int m_ph   [N_CH];
    int p_duty [N_CH];
    int p_ph   [N_CH];
    int m_prev [N_CH];
    int m_stab [N_CH];
    int m_edt  [N_CH];
    logic [N_CH-1:0] e_hi, e_lo;
    logic            e_sync, e_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_per = 0; m_dt = 0; m_pend = 0; p_per = 0; p_dt = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_duty[i] = 0; m_ph[i] = 0; p_duty[i] = 0; p_ph[i] = 0;
            m_prev[i] = 0; m_stab[i] = BIG; m_edt[i] = 0;
        end
        e_hi = '0; e_lo = '0; e_sync = 1'b0; e_ack = 1'b0;
    endtask

    task automatic model_step();
        bit act, wrp, cmt;
        bit r;
        act = en && (m_per != 0);
        for (int i = 0; i < N_CH; i++) begin
            r = act && (((m_cnt + m_ph[i]) % (act ? m_per : 1)) < m_duty[i]);
`ifdef PWM_MULTIPHASE_DEADTIME_EN
            if (!act) begin
                m_prev[i] = 0; m_stab[i] = BIG;
                e_hi[i] = 1'b0; e_lo[i] = 1'b0;
            end else begin
                if (int'(r) != m_prev[i]) begin
                    m_prev[i] = r; m_stab[i] = 0; m_edt[i] = m_dt;
                end else if (m_stab[i] < BIG) begin
                    m_stab[i]++;
                end
                e_hi[i] = (m_stab[i] >= m_edt[i]) && r;
                e_lo[i] = (m_stab[i] >= m_edt[i]) && !r;
            end
`else
            e_hi[i] = r;
            e_lo[i] = act && !r;
`endif
        end
        wrp    = (m_per == 0) || (m_cnt == m_per - 1);
        cmt    = m_pend && (!en || wrp);
        e_sync = act && wrp;
        e_ack  = cmt;
        m_cnt  = act ? (wrp ? 0 : m_cnt + 1) : 0;
        if (cmt) begin
            m_per = p_per; m_dt = p_dt; m_pend = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_duty[i] = p_duty[i];
                m_ph[i]   = (p_ph[i] >= p_per) ? ((p_per == 0) ? 0 : p_per - 1) : p_ph[i];
            end
        end
        if (load) begin
            m_pend = 1; p_per = period; p_dt = dead_time;
            for (int i = 0; i < N_CH; i++) begin
                p_duty[i] = duty[i*CNT_W +: CNT_W];
                p_ph[i]   = phase[i*CNT_W +: CNT_W];
            end
        end
    endtask

    task automatic compare_all();
        check("gate_hi",  32'(gate_hi),  32'(e_hi));
        check("gate_lo",  32'(gate_lo),  32'(e_lo));
        check("sync",     32'(sync),     32'(e_sync));
        check("load_ack", 32'(load_ack), 32'(e_ack));
        check("no_overlap", 32'(gate_hi & gate_lo), 32'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_ch(input int i, input int d, input int p);
        duty[i*CNT_W +: CNT_W]  = CNT_W'(d);
        phase[i*CNT_W +: CNT_W] = CNT_W'(p);
    endtask

    task automatic do_load(input int per, input int dt);
        period    = CNT_W'(per);
        dead_time = DT_W'(dt);
        load      = 1'b1;
        cyc();
        load      = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int budget;
        budget = 0;
        while (m_cnt != target && budget < 400) begin
            cyc();
            budget++;
        end
        check("wait_cnt_timeout", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; period = '0; duty = '0; phase = '0; dead_time = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Single-phase 50 % duty; committed while disabled, then enabled.
        for (int i = 0; i < N_CH; i++) set_ch(i, 5, 0);
        do_load(10, 0);
        run(2);
        en = 1'b1;
        run(40);

        // Interleaved four-phase.
        for (int i = 0; i < N_CH; i++) set_ch(i, 50, 25 * i);
        do_load(100, 0);
        run(250);

        // Mid-period reload and overwrite before wrap.
        wait_cnt(30);
        for (int i = 0; i < N_CH; i++) set_ch(i, 80, 25 * i);
        do_load(100, 0);
        run(8);
        for (int i = 0; i < N_CH; i++) set_ch(i, 70, 25 * i);
        do_load(100, 0);
        run(200);

        // Duty boundaries and out-of-range phase.
        set_ch(0, 0, 0); set_ch(1, 100, 10); set_ch(2, 150, 0); set_ch(3, 40, 130);
        do_load(100, 0);
        run(220);

        // Zero period.
        do_load(0, 0);
        run(30);

        // Dead-time patterns (ignored by the default build).
        for (int i = 0; i < N_CH; i++) set_ch(i, 10, 5 * i);
        do_load(20, 3);
        run(80);
        do_load(20, 12);
        run(80);

        // Reset mid-period with a load pending.
        for (int i = 0; i < N_CH; i++) set_ch(i, 50, 25 * i);
        do_load(100, 0);
        wait_cnt(36);
        for (int i = 0; i < N_CH; i++) set_ch(i, 20, 0);
        do_load(100, 0);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        run(3);
        rst = 1'b0;
        run(20);
        do_load(30, 2);
        run(40);

        // Enable drop mid-run.
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(40);

        // Randomized reloads and enable toggling.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N_CH; i++)
                set_ch(i, $urandom_range(0, 45), $urandom_range(0, 50));
            if ($urandom_range(0, 5) == 0) en = ~en;
            do_load($urandom_range(0, 40), $urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) begin
                run($urandom_range(0, 3));
                do_load($urandom_range(1, 40), $urandom_range(0, 6));
            end
            run($urandom_range(5, 90));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
